square_draw_arbiter: RTL and testbench



---
 rtl/draw_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/square_draw_arbiter.sv | 156 +++++++++++++++
 tb/tb_square_draw_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared widths, screen bounds, FSM states and square payload for the square draw arbiter.
package draw_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  // Operands of the square currently being plotted
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } square_t;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending request after the last grant; pointer moves on accept.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_valid_c
);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the nearest pending requester after last wins
  always_comb begin
    grant_idx_c   = last;
    grant_valid_c = 1'b0;
    cand          = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(last) + N_REQ - k) % N_REQ);
      if (req[cand]) begin
        grant_idx_c   = cand;
        grant_valid_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last <= IDX_W'(N_REQ - 1);
    end else if (accept) begin
      last <= grant_idx_c;
    end
  end

endmodule

// File: rtl/square_draw_arbiter.sv
// Shares one VGA plot port among N_REQ requesters, plotting one filled square per grant.
// Optional clipping to the visible screen is enabled by defining SQUARE_DRAW_ARB_CLIP_EN.
module square_draw_arbiter
  import draw_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SQ_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [X_W*N_REQ-1:0]   req_x,
  input  logic [Y_W*N_REQ-1:0]   req_y,
  input  logic [COL_W*N_REQ-1:0] req_colour,
  input  logic [N_REQ-1:0]       req_erase,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   plot,
  output logic                   busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 2 * SQ_LOG2;
  localparam logic [CNT_W-1:0] LAST_PIX = '1;

  state_e state, state_next;

  logic [IDX_W-1:0] grant_idx_c;
  logic             grant_valid_c;
  logic             accept_c;
  logic [IDX_W-1:0] owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next, pix_c;
  square_t          sq, sq_next, sel_c;

  logic [N_REQ-1:0] ack_next, done_next;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic [COL_W-1:0] colour_next;
  logic             plot_next, busy_next;

  assign accept_c = (state == IDLE) && grant_valid_c;
  assign pix_c    = cnt + CNT_W'(1);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk           (clk),
    .resetn        (resetn),
    .req           (req),
    .accept        (accept_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // Operand mux for the requester being granted; erase overrides colour
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == grant_idx_c) begin
        sel_c.x      = req_x[i*X_W +: X_W];
        sel_c.y      = req_y[i*Y_W +: Y_W];
        sel_c.colour = req_erase[i] ? COLOUR_BLACK : req_colour[i*COL_W +: COL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid_c) state_next = DRAW;
      DRAW:    if (cnt == LAST_PIX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; the granting edge already emits pixel (0,0)
  always_comb begin
    ack_next    = '0;
    done_next   = '0;
    plot_next   = 1'b0;
    busy_next   = (state_next == DRAW);
    x_next      = vga_x;
    y_next      = vga_y;
    colour_next = vga_colour;
    cnt_next    = cnt;
    sq_next     = sq;
    owner_next  = owner;
    case (state)
      IDLE: begin
        if (grant_valid_c) begin
          sq_next               = sel_c;
          owner_next            = grant_idx_c;
          cnt_next              = '0;
          ack_next[grant_idx_c] = 1'b1;
          x_next                = sel_c.x;
          y_next                = sel_c.y;
          colour_next           = sel_c.colour;
          plot_next             = 1'b1;
        end
      end
      DRAW: begin
        if (cnt == LAST_PIX) begin
          done_next[owner] = 1'b1;
          cnt_next         = '0;
        end else begin
          cnt_next  = pix_c;
          x_next    = sq.x + X_W'(pix_c[SQ_LOG2-1:0]);
          y_next    = sq.y + Y_W'(pix_c[CNT_W-1:SQ_LOG2]);
          plot_next = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef SQUARE_DRAW_ARB_CLIP_EN
    plot_next = plot_next && on_screen(x_next, y_next);
`else
    plot_next = plot_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack        <= '0;
      done       <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      cnt        <= '0;
      sq         <= '0;
      owner      <= '0;
    end else begin
      ack        <= ack_next;
      done       <= done_next;
      plot       <= plot_next;
      busy       <= busy_next;
      vga_x      <= x_next;
      vga_y      <= y_next;
      vga_colour <= colour_next;
      cnt        <= cnt_next;
      sq         <= sq_next;
      owner      <= owner_next;
    end
  end

endmodule

// File: tb/tb_square_draw_arbiter.sv
// Randomised and directed bench for square_draw_arbiter against a pixel-list reference model.
module tb_square_draw_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  req = '0;
  logic [8*N-1:0] req_x = '0;
  logic [7*N-1:0] req_y = '0;
  logic [3*N-1:0] req_colour = '0;
  logic [N-1:0]  req_erase = '0;
  logic [N-1:0]  ack, done;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          plot, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  square_draw_arbiter #(.N_REQ(N), .SQ_LOG2(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_erase  (req_erase),
    .ack        (ack),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy)
  );

  // Reference: a grant turns into 16 pixel records followed by one done record
  typedef struct {
    bit       pix;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] col;
    bit       plot;
    bit       busy;
    bit [N-1:0] done;
  } exp_t;

  exp_t q[$];
  int   m_last = N - 1;
  bit [N-1:0] e_ack, e_done;
  bit   e_plot, e_busy, e_pix, e_rst;
  bit [7:0] e_x;
  bit [6:0] e_y;
  bit [2:0] e_col;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    e_ack = '0; e_done = '0; e_plot = 0; e_busy = 0; e_pix = 0; e_rst = 0;
    if (!resetn) begin
      q.delete();
      m_last = N - 1;
      e_rst = 1; e_x = '0; e_y = '0; e_col = '0;
    end else begin
      if (q.size() == 0 && req != '0) begin
        int g;
        bit [7:0] bx;
        bit [6:0] by;
        bit [2:0] bc;
        exp_t e;
        g = pick(req, m_last);
        m_last = g;
        e_ack[g] = 1'b1;
        bx = req_x[g*8 +: 8];
        by = req_y[g*7 +: 7];
        bc = req_erase[g] ? 3'b000 : req_colour[g*3 +: 3];
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            e.pix = 1; e.busy = 1; e.done = '0; e.col = bc;
            e.x = bx + 8'(c);
            e.y = by + 7'(r);
`ifdef SQUARE_DRAW_ARB_CLIP_EN
            e.plot = (e.x < 8'd160) && (e.y < 7'd120);
`else
            e.plot = 1;
`endif
            q.push_back(e);
          end
        end
        e = '{pix: 0, x: 0, y: 0, col: 0, plot: 0, busy: 0, done: '0};
        e.done[g] = 1'b1;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        e_pix = e.pix; e_plot = e.plot; e_busy = e.busy; e_done = e.done;
        e_x = e.x; e_y = e.y; e_col = e.col;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input bit [7:0] x, input bit [6:0] y,
                        input bit [2:0] c, input bit er);
    req_x[i*8 +: 8]      = x;
    req_y[i*7 +: 7]      = y;
    req_colour[i*3 +: 3] = c;
    req_erase[i]         = er;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if ($urandom_range(0, 9) != 0) req[i] = 1'b0;
      end else if (!req[i] && $urandom_range(0, 15) == 0) begin
        set_op(i, 8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0));
        req[i] = 1'b1;
      end else if (req[i] && $urandom_range(0, 63) == 0) begin
        req[i] = 1'b0;
      end
    end
    resetn = ($urandom_range(0, 799) != 0);
  endtask

  task automatic tick();
    @(negedge clk);
    check("ack", 32'(ack), 32'(e_ack));
    check("ack_onehot", 32'($countones(ack) <= 1), 32'(1));
    check("done", 32'(done), 32'(e_done));
    check("plot", 32'(plot), 32'(e_plot));
    check("busy", 32'(busy), 32'(e_busy));
    if (e_pix || e_rst) begin
      check("vga_x", 32'(vga_x), 32'(e_x));
      check("vga_y", 32'(vga_y), 32'(e_y));
      check("vga_colour", 32'(vga_colour), 32'(e_col));
    end
    if (rand_mode) rand_drive();
    else req = req & ~ack;
  endtask

  task automatic wait_ack(input int i);
    bit seen;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      seen = ack[i];
    end
    check("ack_wait", 32'(seen), 32'(1));
  endtask

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Single coloured square
    set_op(1, 8'd10, 7'd20, 3'b101, 1'b0);
    req[1] = 1'b1;
    wait_ack(1);
    repeat (20) tick();

    // Erase forces black
    set_op(0, 8'd40, 7'd50, 3'b111, 1'b1);
    req[0] = 1'b1;
    wait_ack(0);
    repeat (20) tick();

    // Full contention, then requester 0 again
    for (int i = 0; i < N; i++) set_op(i, 8'(16 * i), 7'(8 * i), 3'(i + 1), 1'b0);
    req = 4'b1111;
    repeat (4 * 17 + 4) tick();
    req[0] = 1'b1;
    wait_ack(0);
    repeat (20) tick();

    // Coordinate wrap at the port widths
    set_op(2, 8'd254, 7'd126, 3'b011, 1'b0);
    req[2] = 1'b1;
    wait_ack(2);
    repeat (20) tick();

    // Reset after the fifth pixel, then priority restarts at requester 0
    set_op(3, 8'd100, 7'd60, 3'b110, 1'b0);
    req[3] = 1'b1;
    wait_ack(3);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    set_op(0, 8'd5, 7'd6, 3'b001, 1'b0);
    req = 4'b1001;
    wait_ack(0);
    repeat (40) tick();

    // Request withdrawn while another square is drawing
    set_op(0, 8'd70, 7'd30, 3'b010, 1'b0);
    req[0] = 1'b1;
    wait_ack(0);
    repeat (2) tick();
    req[2] = 1'b1;
    repeat (3) tick();
    req[2] = 1'b0;
    repeat (25) tick();

    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    resetn = 1'b1;
    req = '0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
